// File: rtl/str_pkt_rr_arb.sv
// Round-robin arbiter that shares one downstream stream unit between CH
// upstream requesters. The selected beat is captured in a forward register
// slice and tagged with its source index, so a downstream demux can route
// the results back.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   idata[CH]       upstream data, one word per channel
//   ilast, ivalid   upstream packet-last and valid, one bit per channel
//   iready          upstream ready, at most one bit high per cycle
//   odata, olast    registered data and last of the selected beat
//   oid             source channel of the current output beat
//   ovalid, oready  downstream handshake
//
// PKT=1 holds the grant on a channel until its ilast beat is accepted.
// PKT=0 re-arbitrates on every beat.
module str_pkt_rr_arb #(
    parameter int CH  = 4,
    parameter int DW  = 16,
    parameter bit PKT = 1'b1,
    localparam int IW = $clog2(CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] idata [CH],
    input  logic [CH-1:0] ilast,
    input  logic [CH-1:0] ivalid,
    output logic [CH-1:0] iready,
    output logic [DW-1:0] odata,
    output logic          olast,
    output logic [IW-1:0] oid,
    output logic          ovalid,
    input  logic          oready
);

    if (CH < 2) begin : g_bad_ch
        $error("str_pkt_rr_arb: CH must be >= 2");
    end

    logic          locked;
    logic [IW-1:0] gnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    logic          found;
    logic          space;
    logic          ish;

    // Forward register slice: a new beat may enter whenever the slot is
    // empty or is being drained in the same cycle.
    assign space = ~ovalid | oready;

    // Search from the channel just after the last packet owner, so the
    // owner of the last completed packet ends up with the lowest priority.
    always_comb begin
        pick  = gnt;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= CH; k++) begin
            idx = IW'((int'(ptr) + k) % CH);
            if (!found && ivalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign sel = locked ? gnt : pick;

    // A locked channel sees iready even while its ivalid is low, so the
    // grant is kept across gaps inside a packet.
    for (genvar i = 0; i < CH; i++) begin : g_rdy
        assign iready[i] = space & (IW'(i) == sel) & (locked | ivalid[i]);
    end

    assign ish = |(ivalid & iready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odata  <= '0;
            olast  <= 1'b0;
            oid    <= '0;
            ovalid <= 1'b0;
            locked <= 1'b0;
            gnt    <= '0;
            ptr    <= IW'(CH - 1);
        end else if (ish) begin
            odata  <= idata[sel];
            olast  <= ilast[sel];
            oid    <= sel;
            ovalid <= 1'b1;
            gnt    <= sel;
            if (PKT) begin
                locked <= ~ilast[sel];
                if (ilast[sel]) ptr <= sel;
            end else begin
                locked <= 1'b0;
                ptr    <= sel;
            end
        end else if (oready) begin
            ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_str_pkt_rr_arb.sv
module tb_str_pkt_rr_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] idata [4];
    logic [3:0] ilast;
    logic [3:0] ivalid;
    logic       oready;

    logic [3:0] iready,   iready_b;
    logic [7:0] odata,    odata_b;
    logic       olast,    olast_b;
    logic [1:0] oid,      oid_b;
    logic       ovalid,   ovalid_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    str_pkt_rr_arb #(.CH(4), .DW(8), .PKT(1'b1)) u_pkt (
        .clk(clk), .rst_n(rst_n), .idata(idata), .ilast(ilast), .ivalid(ivalid),
        .iready(iready), .odata(odata), .olast(olast), .oid(oid),
        .ovalid(ovalid), .oready(oready)
    );

    str_pkt_rr_arb #(.CH(4), .DW(8), .PKT(1'b0)) u_beat (
        .clk(clk), .rst_n(rst_n), .idata(idata), .ilast(ilast), .ivalid(ivalid),
        .iready(iready_b), .odata(odata_b), .olast(olast_b), .oid(oid_b),
        .ovalid(ovalid_b), .oready(oready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ivalid = '0;
        ilast = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] b;
        logic [3:0] hs;
        int ord;

        for (int i = 0; i < 4; i++) idata[i] = '0;
        oready = 1'b1;

        // reset state
        do_reset();
        chk("rst_ovalid", ovalid, 0);
        chk("rst_iready", iready, 4'b0000);
        chk("rst_odata", odata, 0);
        chk("rst_oid", oid, 0);

        // ch1 three-beat packet
        ivalid = 4'b0010; idata[1] = 8'h11;
        #1 chk("c1_iready", iready, 4'b0010);
        step();
        chk("c1_d0", odata, 8'h11); chk("c1_id0", oid, 1); chk("c1_l0", olast, 0); chk("c1_v0", ovalid, 1);
        idata[1] = 8'h12;
        step();
        chk("c1_d1", odata, 8'h12); chk("c1_l1", olast, 0);
        idata[1] = 8'h13; ilast = 4'b0010;
        step();
        chk("c1_d2", odata, 8'h13); chk("c1_l2", olast, 1); chk("c1_id2", oid, 1);
        ivalid = '0; ilast = '0;
        step();
        chk("c1_idle", ovalid, 0);

        // asynchronous reset mid-packet
        ivalid = 4'b0010; idata[1] = 8'h14;
        step();
        chk("ar_pre", ovalid, 1);
        ivalid = '0;
        #2 rst_n = 1'b0;
        #1 chk("ar_async", ovalid, 0);
        chk("ar_odata", odata, 0);
        #2 rst_n = 1'b1;
        step();

        // all channels valid, two-beat packets: 0,0,1,1,2,2,3,3,...
        b = '0;
        ivalid = 4'b1111;
        for (int i = 0; i < 4; i++) idata[i] = 8'(i * 16);
        ilast = b;
        for (int n = 0; n < 16; n++) begin
            #1;
            hs = ivalid & iready;
            chk("rr_onehot", 32'($countones(iready) <= 1), 1);
            step();
            b = b ^ hs;
            ord = (n / 2) % 4;
            chk("rr_v", ovalid, 1);
            chk("rr_oid", oid, ord);
            chk("rr_olast", olast, n % 2);
            chk("rr_odata", odata, ord * 16 + (n % 2));
            for (int i = 0; i < 4; i++) idata[i] = 8'(i * 16 + b[i]);
            ilast = b;
        end
        ivalid = '0; ilast = '0;
        step();
        chk("rr_idle", ovalid, 0);

        // ch2 locked, drops valid mid-packet while ch0 waits
        ivalid = 4'b0100; idata[2] = 8'h21;
        step();
        chk("lk_oid0", oid, 2); chk("lk_d0", odata, 8'h21); chk("lk_l0", olast, 0);
        ivalid = 4'b0001; idata[0] = 8'h01; ilast = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            #1 chk("lk_hold", iready, 4'b0100);
            step();
            chk("lk_gap", ovalid, 0);
        end
        ivalid = 4'b0101; idata[2] = 8'h22; ilast = 4'b0101;
        #1 chk("lk_res", iready, 4'b0100);
        step();
        chk("lk_oid1", oid, 2); chk("lk_d1", odata, 8'h22); chk("lk_l1", olast, 1);
        chk("lk_c0rdy", iready, 4'b0001);
        step();
        chk("lk_c0oid", oid, 0); chk("lk_c0d", odata, 8'h01); chk("lk_c0l", olast, 1);
        ivalid = '0; ilast = '0;
        step();
        chk("lk_idle", ovalid, 0);

        // backpressure with ch3
        ivalid = 4'b1000; idata[3] = 8'h31;
        step();
        chk("bp_d0", odata, 8'h31); chk("bp_id0", oid, 3);
        oready = 1'b0; idata[3] = 8'h32; ilast = 4'b1000;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("bp_rdy", iready, 4'b0000);
            chk("bp_d", odata, 8'h31);
            chk("bp_id", oid, 3);
            chk("bp_l", olast, 0);
            chk("bp_v", ovalid, 1);
            step();
        end
        oready = 1'b1;
        #1 chk("bp_rel", iready, 4'b1000);
        step();
        chk("bp_d1", odata, 8'h32); chk("bp_l1", olast, 1); chk("bp_v1", ovalid, 1); chk("bp_id1", oid, 3);
        ivalid = '0; ilast = '0;
        step();
        chk("bp_idle", ovalid, 0);

        // PKT=0: ch0 and ch1 alternate per beat regardless of ilast
        do_reset();
        ivalid = 4'b0011; idata[0] = 8'hA0; idata[1] = 8'hB1; ilast = 4'b0010;
        #1 chk("pb_rdy0", iready_b, 4'b0001);
        for (int n = 0; n < 8; n++) begin
            step();
            chk("pb_v", ovalid_b, 1);
            chk("pb_oid", oid_b, n % 2);
            chk("pb_d", odata_b, (n % 2) ? 8'hB1 : 8'hA0);
            chk("pb_l", olast_b, n % 2);
            chk("pb_rdy", iready_b, (n % 2) ? 4'b0001 : 4'b0010);
        end
        ivalid = '0; ilast = '0;
        step();
        chk("pb_idle", ovalid_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/str_pkt_rr_arb.md
Name: str_pkt_rr_arb

Overview:
- Round-robin arbiter that shares one downstream stream unit between CH upstream requesters, e.g. a single str_fpmul or str_addsub.
- Grants whole packets (locked until the ilast beat) or single beats.
- Registers the selected beat in a forward register slice and tags it with the source index, so a downstream demux can route results back.
- Sits in front of a shared stream unit.

Parameters:
CH, 4, number of upstream requesters (>= 2; CH < 2 raises $error at elaboration)
DW, 16, data width
PKT, 1, 1 = lock grant until ilast handshake; 0 = re-arbitrate every beat
IW, $clog2(CH), width of source id (localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
idata  in  [DW-1:0] x CH (unpacked)  upstream data
ilast  in  1 x CH  upstream packet last
ivalid  in  1 x CH  upstream valid
iready  out  1 x CH  upstream ready, at most one high per cycle
odata  out  DW  registered selected data
olast  out  1  registered last
oid  out  IW  index of source of current output beat
ovalid  out  1  output valid
oready  in  1  downstream ready

Behaviour:
- One clock domain. Reset is asynchronous and active-low: asserting rst_n=0 clears every register immediately, with no clock required.
- Reset values:
  - Outputs: odata=0, olast=0, oid=0, ovalid=0.
  - Internal: locked=0, gnt=0, ptr=CH-1, so channel 0 has top priority after reset.
- Handshakes: ish_i = ivalid[i] & iready[i]; osh = ovalid & oready.
- Space available: space = ~ovalid | oready. This is forward-regslice semantics and gives full throughput.
- Selection, combinational:
  - If locked: sel = gnt.
  - Otherwise: sel = first i with ivalid[i], searching ptr+1, ptr+2, ... modulo CH.
  - If no ivalid, sel = gnt and no grant is issued.
- iready[i] = space & (i == sel) & (locked | ivalid[i]).
- iready must never be asserted for a non-selected channel. The spec does not require iready to be independent of ivalid.
- On ish of sel, at the next edge:
  - odata <= idata[sel], olast <= ilast[sel], oid <= sel, ovalid <= 1.
  - gnt <= sel.
  - If PKT=1: locked <= ~ilast[sel].
  - If PKT=1 and ilast[sel]: ptr <= sel.
  - If PKT=0: locked stays 0 and ptr <= sel on every beat.
- If there is no ish and oready=1: ovalid <= 0. Otherwise ovalid holds.
- Output registers hold while ovalid & ~oready. This gives stable data under backpressure.
- Latency is 1 cycle from input handshake to ovalid.
- Packet switch costs no bubble: the beat after a last may come from a new channel on the very next cycle.
- Locked behaviour:
  - A locked channel that drops ivalid mid-packet keeps the grant; other channels wait. This is no-starvation-by-interleave.
  - Fairness: after a completed packet from channel k, channel k has lowest priority. Worst-case wait is (CH-1) packets.
- A single-beat packet (ilast on the first beat) never sets locked.
- Simultaneous events:
  - ish and osh in the same cycle: the new beat replaces the old one and ovalid stays 1.
  - ilast beat plus a new request on another channel in the same cycle: the request is arbitrated next cycle, using the updated ptr.
- Reset mid-packet: the lock is dropped, and the partial packet in the output register is discarded. Upstreams must restart packets.

Test Plan:
- Reset, CH=4, DW=8, PKT=1, all ivalid=0: after release ovalid=0, iready=4'b0000. With rst_n=0 asserted mid-cycle, ovalid falls asynchronously.
- Ch1 sends a 3-beat packet 0x11,0x12,0x13(last), oready=1: odata sequence 0x11,0x12,0x13 on consecutive cycles, oid=1, olast only on 0x13, latency 1.
- All 4 channels continuously valid with 2-beat packets: grant order 0,1,2,3,0,... Packets never interleave, and ovalid stays high with no bubbles.
- Ch2 locked, drops ivalid for 3 cycles mid-packet while ch0 valid: iready[0] stays 0 and ch2 resumes. Ch0 is granted only after ch2's last beat.
- oready held 0 for 5 cycles with ch3 valid: odata/oid/olast stay stable and iready all 0. On oready=1, the pending beat and the next beat flow back-to-back.
- PKT=0, ch0 and ch1 both valid with long packets: beats alternate 0,1,0,1 regardless of ilast, and oid tracks each beat.
